fetch_decode_stage: RTL and testbench
=====================================

FETCH_DECODE_STAGE -- requirements
Module: fetch_decode_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), is the bubble instruction injected on flush and reset.
REQ-003 Parameter CNT_W, default 16, is the width of the performance counters.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 stall_f  input  1  hold PC (from hazard unit).
REQ-007 stall_d  input  1  hold IF/ID register (from hazard unit).
REQ-008 flush_d  input  1  bubble IF/ID register (from hazard unit).
REQ-009 pcsrc_e  input  1  taken branch/jump redirect from Execute.
REQ-010 pctarget_e  input  32  redirect target from Execute.
REQ-011 imem_addr  output  32  instruction memory address, equal to pc_f (combinational read memory).
REQ-012 imem_rdata  input  32  instruction word at imem_addr, same cycle.
REQ-013 instr_d, pc_d, pcplus4_d  output  32 each  IF/ID register contents.
REQ-014 valid_d  output  1  instr_d holds a real fetched instruction, not a bubble.
REQ-015 misalign_err  output  1  sticky: a redirect target had bits [1:0] != 0.
REQ-016 stall_cnt, flush_cnt  output  CNT_W each  saturating performance counters.

Function
REQ-017 pc_f next value SHALL be: pcsrc_e=1 -> {pctarget_e[31:2],2'b00}; else stall_f=1 -> hold; else pc_f+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-018 pcsrc_e SHALL take priority over stall_f when both are asserted in the same cycle.
REQ-019 IF/ID update SHALL be: flush_d=1 -> instr_d=NOP_INSTR, pc_d=0, pcplus4_d=0, valid_d=0; else stall_d=1 -> hold all four; else instr_d=imem_rdata, pc_d=pc_f, pcplus4_d=pc_f+4 (32-bit wrap), valid_d=1.
REQ-020 flush_d SHALL take priority over stall_d.
REQ-021 Fetch-to-decode latency SHALL be exactly one cycle: the word addressed in cycle N appears on instr_d in cycle N+1 absent stall/flush.
REQ-022 misalign_err SHALL set in the cycle after a redirect with pctarget_e[1:0] != 0 and remain set until reset.
REQ-023 stall_cnt SHALL increment by 1 on each edge where stall_f=1 and pcsrc_e=0, saturating at all-ones.
REQ-024 flush_cnt SHALL increment by 1 on each edge where flush_d=1, saturating at all-ones.
REQ-025 All outputs except imem_addr SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-026 While rst_n=0: pc_f=RESET_PC, instr_d=NOP_INSTR, pc_d=0, pcplus4_d=0, valid_d=0, misalign_err=0, both counters=0.
REQ-027 Reset assertion mid-operation SHALL clear state immediately, independent of clk, and discard any pending redirect.
REQ-028 The first edge after rst_n deasserts SHALL capture the word at RESET_PC into instr_d with valid_d=1.

Structure
REQ-029 XLEN (32), NOP_INSTR, the default RESET_PC and the 4-byte instruction step SHALL live in the shared pipeline package.
REQ-030 The IF/ID register SHALL be built from one sub-module, pipe_reg_en_clr (parameterised width, enable, synchronous clear, asynchronous reset value), reusable for the other stage registers.
REQ-031 Counters and the PC register SHALL remain in the top module.

Verification
REQ-032 Reset release, no hazards, imem returns word = address -> instr_d 0x0,0x4,0x8 on successive cycles, valid_d=1.
REQ-033 stall_f=stall_d=1 for 2 cycles at pc_f=0x10 -> pc_f holds 0x10, instr_d holds, stall_cnt increases by 2.
REQ-034 pcsrc_e=1, pctarget_e=0x100, flush_d=1 -> next cycle pc_f=0x100, valid_d=0, instr_d=NOP_INSTR; following cycle instr_d=mem[0x100].
REQ-035 pcsrc_e=1 with stall_f=1, and flush_d=1 with stall_d=1, simultaneously -> PC loads target, IF/ID bubbles.
REQ-036 pctarget_e=0x203 redirect -> pc_f=0x200, misalign_err=1 and sticky across 10 further cycles.
REQ-037 pc_f=0xFFFF_FFFC without hazards -> pc_f wraps to 0x0; CNT_W=4 with 20 stall cycles -> stall_cnt=4'hF; rst_n pulse mid-stall -> all REQ-026 values.

Source files
------------

// File: rtl/fetch_decode_stage_pkg.sv
// Shared pipeline definitions: machine width, bubble encoding, reset PC and the
// IF/ID register layout used by the fetch/decode boundary.
package fetch_decode_stage_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_STEP    = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
    logic            valid;
  } if_id_t;

  localparam int unsigned IF_ID_W = $bits(if_id_t);

endpackage

// File: rtl/pipe_reg_en_clr.sv
// Generic pipeline register: asynchronous reset value, synchronous clear that
// wins over the enable, and hold when the enable is low.
module pipe_reg_en_clr #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter logic [WIDTH-1:0]  CLR_VAL   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  // Register with clear-over-enable priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= RESET_VAL;
    end else if (clr_i) begin
      data_q <= CLR_VAL;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/fetch_decode_stage.sv
// Fetch stage PC plus the IF/ID boundary register, with a sticky misaligned
// redirect flag and saturating stall/flush performance counters.
module fetch_decode_stage
  import fetch_decode_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter int unsigned     CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_f,
  input  logic             stall_d,
  input  logic             flush_d,
  input  logic             pcsrc_e,
  input  logic [XLEN-1:0]  pctarget_e,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic [XLEN-1:0]  instr_d,
  output logic [XLEN-1:0]  pc_d,
  output logic [XLEN-1:0]  pcplus4_d,
  output logic             valid_d,
  output logic             misalign_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam if_id_t         IF_ID_BUBBLE = '{instr: NOP_INSTR, pc: '0, pcplus4: '0, valid: 1'b0};
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [XLEN-1:0]  pc_f_q, pc_f_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  if_id_t           if_id_d, if_id_q;

  // Next PC: redirect beats stall; the target is forced word aligned.
  always_comb begin
    pc_f_d = pc_f_q;
    if (pcsrc_e) begin
      pc_f_d = {pctarget_e[XLEN-1:2], 2'b00};
    end else if (!stall_f) begin
      pc_f_d = pc_f_q + INSTR_STEP;
    end
  end

  // Sticky flag and saturating counters.
  always_comb begin
    misalign_d  = misalign_q | (pcsrc_e & (pctarget_e[1:0] != 2'b00));
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    // A redirect overrides the stall, so that cycle is not a lost fetch.
    if (stall_f && !pcsrc_e && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush_d && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // Fetch-side state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f_q      <= RESET_PC;
      misalign_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_f_q      <= pc_f_d;
      misalign_q  <= misalign_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Word fetched this cycle, as it should appear in decode next cycle.
  always_comb begin
    if_id_d = '{instr: imem_rdata, pc: pc_f_q, pcplus4: pc_f_q + INSTR_STEP, valid: 1'b1};
  end

  pipe_reg_en_clr #(
    .WIDTH     (IF_ID_W),
    .RESET_VAL (IF_ID_BUBBLE),
    .CLR_VAL   (IF_ID_BUBBLE)
  ) u_if_id (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (!stall_d),
    .clr_i (flush_d),
    .d_i   (if_id_d),
    .q_o   (if_id_q)
  );

  assign imem_addr    = pc_f_q;
  assign instr_d      = if_id_q.instr;
  assign pc_d         = if_id_q.pc;
  assign pcplus4_d    = if_id_q.pcplus4;
  assign valid_d      = if_id_q.valid;
  assign misalign_err = misalign_q;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Bench for fetch_decode_stage: two instances (16-bit and 4-bit counters) share
// stimulus; a behavioural model is compared on every falling edge, and directed
// scenarios pin the model with literal expectations.
module tb_fetch_decode_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0, pcsrc_e = 1'b0;
  logic [31:0] pctarget_e = '0;
  logic        mem_mode = 1'b0;
  logic        cmp_en = 1'b0;

  logic [31:0] addr_a, rdata_a, instr_a, pcd_a, pcp4_a;
  logic        valid_a, mis_a;
  logic [15:0] sc_a, fc_a;
  logic [31:0] addr_b, rdata_b, instr_b, pcd_b, pcp4_b;
  logic        valid_b, mis_b;
  logic [3:0]  sc_b, fc_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] scr(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign rdata_a = mem_mode ? scr(addr_a) : addr_a;
  assign rdata_b = mem_mode ? scr(addr_b) : addr_b;

  fetch_decode_stage u_dut (
    .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .pcsrc_e(pcsrc_e), .pctarget_e(pctarget_e), .imem_addr(addr_a), .imem_rdata(rdata_a),
    .instr_d(instr_a), .pc_d(pcd_a), .pcplus4_d(pcp4_a), .valid_d(valid_a),
    .misalign_err(mis_a), .stall_cnt(sc_a), .flush_cnt(fc_a)
  );

  fetch_decode_stage #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .pcsrc_e(pcsrc_e), .pctarget_e(pctarget_e), .imem_addr(addr_b), .imem_rdata(rdata_b),
    .instr_d(instr_b), .pc_d(pcd_b), .pcplus4_d(pcp4_b), .valid_d(valid_b),
    .misalign_err(mis_b), .stall_cnt(sc_b), .flush_cnt(fc_b)
  );

  // Behavioural model: PC, decode slot, sticky flag and raw (unsaturated) event counts.
  logic [31:0] m_pc, m_instr, m_pcd, m_pcp4;
  logic        m_valid, m_mis;
  int unsigned m_sc, m_fc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 32'h0; m_instr <= NOP; m_pcd <= '0; m_pcp4 <= '0;
      m_valid <= 1'b0; m_mis <= 1'b0; m_sc <= 0; m_fc <= 0;
    end else begin
      if (flush_d) begin
        m_instr <= NOP; m_pcd <= '0; m_pcp4 <= '0; m_valid <= 1'b0;
        m_fc <= m_fc + 1;
      end else if (!stall_d) begin
        m_instr <= mem_mode ? scr(m_pc) : m_pc;
        m_pcd <= m_pc; m_pcp4 <= m_pc + 32'd4; m_valid <= 1'b1;
      end
      if (pcsrc_e) begin
        m_pc <= pctarget_e & ~32'd3;
        if (pctarget_e % 4 != 0) m_mis <= 1'b1;
      end else if (!stall_f) begin
        m_pc <= m_pc + 32'd4;
      end
      if (stall_f && !pcsrc_e) m_sc <= m_sc + 1;
    end
  end

  function automatic logic [31:0] sat(input int unsigned v, input int unsigned w);
    int unsigned mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("addr", addr_a, m_pc);
      check("instr", instr_a, m_instr);
      check("pc_d", pcd_a, m_pcd);
      check("pcplus4_d", pcp4_a, m_pcp4);
      check("valid_d", 32'(valid_a), 32'(m_valid));
      check("misalign", 32'(mis_a), 32'(m_mis));
      check("stall_cnt16", 32'(sc_a), sat(m_sc, 16));
      check("flush_cnt16", 32'(fc_a), sat(m_fc, 16));
      check("addr4", addr_b, m_pc);
      check("instr4", instr_b, m_instr);
      check("pc_d4", pcd_b, m_pcd);
      check("valid_d4", 32'(valid_b), 32'(m_valid));
      check("stall_cnt4", 32'(sc_b), sat(m_sc, 4));
      check("flush_cnt4", 32'(fc_b), sat(m_fc, 4));
    end
  end

  task automatic clear_in();
    stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; pcsrc_e = 1'b0; pctarget_e = '0;
  endtask

  task automatic reset_vals(input string tag);
    check({tag, "_addr"}, addr_a, 32'h0);
    check({tag, "_instr"}, instr_a, NOP);
    check({tag, "_pc_d"}, pcd_a, 32'h0);
    check({tag, "_pcplus4"}, pcp4_a, 32'h0);
    check({tag, "_valid"}, 32'(valid_a), 32'h0);
    check({tag, "_mis"}, 32'(mis_a), 32'h0);
    check({tag, "_sc"}, 32'(sc_a), 32'h0);
    check({tag, "_fc"}, 32'(fc_a), 32'h0);
    check({tag, "_sc4"}, 32'(sc_b), 32'h0);
  endtask

  initial begin
    bit rst_pending;
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    #1 reset_vals("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch after release, memory returns its own address.
    @(negedge clk); check("seq0_instr", instr_a, 32'h0); check("seq0_valid", 32'(valid_a), 32'h1);
    @(negedge clk); check("seq1_instr", instr_a, 32'h4);
    @(negedge clk); check("seq2_instr", instr_a, 32'h8); check("seq2_pcplus4", pcp4_a, 32'hC);
    @(negedge clk); check("pre_stall_addr", addr_a, 32'h10);

    // Two-cycle stall of both PC and IF/ID.
    stall_f = 1'b1; stall_d = 1'b1;
    repeat (2) @(negedge clk);
    check("stall_addr", addr_a, 32'h10);
    check("stall_instr", instr_a, 32'hC);
    check("stall_cnt2", 32'(sc_a), 32'd2);
    clear_in();

    // Redirect with flush.
    pcsrc_e = 1'b1; pctarget_e = 32'h100; flush_d = 1'b1;
    @(negedge clk);
    check("redir_addr", addr_a, 32'h100);
    check("redir_valid", 32'(valid_a), 32'h0);
    check("redir_instr", instr_a, NOP);
    check("redir_fc", 32'(fc_a), 32'd1);
    clear_in();
    @(negedge clk);
    check("tgt_instr", instr_a, 32'h100);
    check("tgt_pc_d", pcd_a, 32'h100);
    check("tgt_valid", 32'(valid_a), 32'h1);

    // Redirect beats stall_f, flush beats stall_d.
    pcsrc_e = 1'b1; stall_f = 1'b1; pctarget_e = 32'h40; flush_d = 1'b1; stall_d = 1'b1;
    @(negedge clk);
    check("prio_addr", addr_a, 32'h40);
    check("prio_valid", 32'(valid_a), 32'h0);
    check("prio_instr", instr_a, NOP);
    check("prio_sc", 32'(sc_a), 32'd2);
    check("prio_fc", 32'(fc_a), 32'd2);
    clear_in();

    // Misaligned redirect target.
    pcsrc_e = 1'b1; pctarget_e = 32'h203;
    @(negedge clk);
    check("mis_addr", addr_a, 32'h200);
    check("mis_set", 32'(mis_a), 32'h1);
    clear_in();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("mis_sticky", 32'(mis_a), 32'h1);
    end

    // PC wrap through the top of the address space.
    pcsrc_e = 1'b1; pctarget_e = 32'hFFFF_FFF8;
    @(negedge clk); check("wrap_f8", addr_a, 32'hFFFF_FFF8);
    clear_in();
    @(negedge clk); check("wrap_fc", addr_a, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_zero", addr_a, 32'h0);
    check("wrap_pc_d", pcd_a, 32'hFFFF_FFFC);
    check("wrap_pcplus4", pcp4_a, 32'h0);

    // Counter saturation on the 4-bit instance.
    stall_f = 1'b1;
    repeat (20) @(negedge clk);
    check("sat_sc4", 32'(sc_b), 32'hF);
    check("sat_sc16", 32'(sc_a), 32'd22);

    // Reset pulse mid-stall with a pending redirect.
    pcsrc_e = 1'b1; pctarget_e = 32'h300;
    #2 rst_n = 1'b0;
    #1 reset_vals("midrst");
    @(negedge clk);
    clear_in();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_addr", addr_a, 32'h4);
    check("post_rst_instr", instr_a, 32'h0);
    check("post_rst_valid", 32'(valid_a), 32'h1);

    // Randomized traffic with scrambled memory contents.
    mem_mode = 1'b1;
    rst_pending = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (rst_pending) begin
        rst_n = 1'b1;
        rst_pending = 1'b0;
      end
      stall_f    = ($urandom_range(0, 3) == 0);
      stall_d    = ($urandom_range(0, 3) == 0);
      flush_d    = ($urandom_range(0, 6) == 0);
      pcsrc_e    = ($urandom_range(0, 9) == 0);
      pctarget_e = $urandom;
      if ($urandom_range(0, 3) != 0) pctarget_e[1:0] = 2'b00;
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        rst_pending = 1'b1;
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
    clear_in();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
